// File: rtl/control_unit_if.sv
// Control bundle between the multicycle control FSM (master) and the datapath (slave).
// Carries the decoded instruction fields, the Zero flag and the datapath controls.
interface control_unit_if #(
  parameter int STATE_WIDTH = 4
);
  logic [5:0]             Op;
  logic [5:0]             Funct;
  logic                   Zero;
  logic                   PC_En;
  logic                   I_or_D;
  logic                   Mem_Write;
  logic                   IR_Write;
  logic [1:0]             Reg_Dst;
  logic [1:0]             Mem_to_Reg;
  logic                   Reg_Write;
  logic                   ALU_Src_A;
  logic [1:0]             ALU_Src_B;
  logic [2:0]             ALU_Control;
  logic [1:0]             PC_Src;
  logic [STATE_WIDTH-1:0] State;

  modport master (
    input  Op, Funct, Zero,
    output PC_En, I_or_D, Mem_Write, IR_Write, Reg_Dst, Mem_to_Reg, Reg_Write,
           ALU_Src_A, ALU_Src_B, ALU_Control, PC_Src, State
  );

  modport slave (
    output Op, Funct, Zero,
    input  PC_En, I_or_D, Mem_Write, IR_Write, Reg_Dst, Mem_to_Reg, Reg_Write,
           ALU_Src_A, ALU_Src_B, ALU_Control, PC_Src, State
  );
endinterface

// File: rtl/control_unit.sv
// Multicycle MIPS-style control FSM: Moore decode of the state register, except the
// branch PC enable (follows Zero combinationally) and the jal link write in DECODE.
module control_unit #(
  parameter int STATE_WIDTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  control_unit_if.master bus
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_RTYPE_EX = 4'd6;
  localparam logic [3:0] S_ALU_WB   = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_ADDI_EX  = 4'd9;
  localparam logic [3:0] S_ADDI_WB  = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [3:0] S_JR       = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_JR  = 6'b001000;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic logic f_funct_known(input logic [5:0] funct);
    logic known;
    case (funct)
      F_ADD, F_SUB, F_AND, F_OR, F_SLT: known = 1'b1;
      default:                          known = 1'b0;
    endcase
    return known;
  endfunction

  function automatic logic [2:0] f_alu_ctrl(input logic [5:0] funct);
    logic [2:0] code;
    case (funct)
      F_ADD:   code = ALU_ADD;
      F_SUB:   code = ALU_SUB;
      F_AND:   code = ALU_AND;
      F_OR:    code = ALU_OR;
      F_SLT:   code = ALU_SLT;
      default: code = 3'b000;
    endcase
    return code;
  endfunction

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic       w_pc_en;
  logic       w_iord;
  logic       w_mem_write;
  logic       w_ir_write;
  logic [1:0] w_reg_dst;
  logic [1:0] w_mem_to_reg;
  logic       w_reg_write;
  logic       w_src_a;
  logic [1:0] w_src_b;
  logic [2:0] w_alu_ctrl;
  logic [1:0] w_pc_src;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = S_FETCH;
    w_pc_en      = 1'b0;
    w_iord       = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_dst    = 2'b00;
    w_mem_to_reg = 2'b00;
    w_reg_write  = 1'b0;
    w_src_a      = 1'b0;
    w_src_b      = 2'b00;
    w_alu_ctrl   = 3'b000;
    w_pc_src     = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_src_b    = 2'b01;
        w_alu_ctrl = ALU_ADD;
        w_ir_write = 1'b1;
        w_pc_en    = 1'b1;
        w_next     = S_DECODE;
      end
      S_DECODE: begin
        w_src_b    = 2'b11;
        w_alu_ctrl = ALU_ADD;
        // jal links here: ALU_Out still holds PC+4 from FETCH
        if (bus.Op == OP_JAL) begin
          w_reg_dst   = 2'b10;
          w_reg_write = 1'b1;
        end else begin
          w_reg_write = 1'b0;
        end
        case (bus.Op)
          OP_LW, OP_SW:   w_next = S_MEMADR;
          OP_RTYPE:       w_next = (bus.Funct == F_JR) ? S_JR : S_RTYPE_EX;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_ADDI:        w_next = S_ADDI_EX;
          OP_J, OP_JAL:   w_next = S_JUMP;
          default:        w_next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        w_src_a    = 1'b1;
        w_src_b    = 2'b10;
        w_alu_ctrl = ALU_ADD;
        if (bus.Op == OP_LW) begin
          w_next = S_MEMRD;
        end else if (bus.Op == OP_SW) begin
          w_next = S_MEMWR;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_MEMRD: begin
        w_iord = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        w_mem_to_reg = 2'b01;
        w_reg_write  = 1'b1;
      end
      S_MEMWR: begin
        w_iord      = 1'b1;
        w_mem_write = 1'b1;
      end
      S_RTYPE_EX: begin
        w_src_a    = 1'b1;
        w_alu_ctrl = f_alu_ctrl(bus.Funct);
        w_next     = f_funct_known(bus.Funct) ? S_ALU_WB : S_FETCH;
      end
      S_ALU_WB: begin
        w_reg_dst   = 2'b01;
        w_reg_write = 1'b1;
      end
      S_BRANCH: begin
        w_src_a    = 1'b1;
        w_alu_ctrl = ALU_SUB;
        w_pc_src   = 2'b01;
        if (bus.Op == OP_BEQ) begin
          w_pc_en = bus.Zero;
        end else if (bus.Op == OP_BNE) begin
          w_pc_en = ~bus.Zero;
        end else begin
          w_pc_en = 1'b0;
        end
      end
      S_ADDI_EX: begin
        w_src_a    = 1'b1;
        w_src_b    = 2'b10;
        w_alu_ctrl = ALU_ADD;
        w_next     = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        w_reg_write = 1'b1;
      end
      S_JUMP: begin
        w_pc_src = 2'b10;
        w_pc_en  = 1'b1;
      end
      S_JR: begin
        w_src_a    = 1'b1;
        w_alu_ctrl = ALU_ADD;
        w_pc_en    = 1'b1;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Write enables are gated by reset so an abort takes effect without waiting for a clock
  assign bus.PC_En       = w_pc_en & reset;
  assign bus.IR_Write    = w_ir_write & reset;
  assign bus.Mem_Write   = w_mem_write & reset;
  assign bus.Reg_Write   = w_reg_write & reset;
  assign bus.I_or_D      = w_iord;
  assign bus.Reg_Dst     = w_reg_dst;
  assign bus.Mem_to_Reg  = w_mem_to_reg;
  assign bus.ALU_Src_A   = w_src_a;
  assign bus.ALU_Src_B   = w_src_b;
  assign bus.ALU_Control = w_alu_ctrl;
  assign bus.PC_Src      = w_pc_src;
  assign bus.State       = STATE_WIDTH'(r_state);

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a per-instruction phase model pushes expected
// control words; a negedge monitor pops and compares them against the DUT outputs.
module tb_control_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  control_unit_if #(.STATE_WIDTH(4)) bus ();
  control_unit #(.STATE_WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef enum int {PH_F, PH_D, PH_MA, PH_MR, PH_MWB, PH_MW, PH_RX, PH_AWB,
                    PH_BR, PH_AX, PH_AWB2, PH_J, PH_JR} phase_e;
  typedef struct {logic [16:0] w; int ph;} exp_t;

  exp_t q[$];
  int   plan_q[$];
  int   checks = 0;
  int   failures = 0;

  logic [5:0] legal_ops [9] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                                6'b001000, 6'b000010, 6'b000011, 6'b000000};
  logic [5:0] r_functs  [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                                6'b001000, 6'b000111};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected control word {PC_En,I_or_D,Mem_Write,IR_Write,Reg_Dst,Mem_to_Reg,Reg_Write,Src_A,Src_B,ALU,PC_Src}
  function automatic logic [16:0] model(int ph, logic [5:0] op, logic [5:0] fn, logic z);
    logic pe = 0, iod = 0, mw = 0, irw = 0, rw = 0, sa = 0;
    logic [1:0] rd = 0, m2r = 0, sb = 0, ps = 0;
    logic [2:0] alu = 0;
    case (ph)
      PH_F:    begin sb = 2'b01; alu = 3'b010; irw = 1; pe = 1; end
      PH_D:    begin sb = 2'b11; alu = 3'b010;
                 if (op == 6'b000011) begin rd = 2'b10; rw = 1; end end
      PH_MA:   begin sa = 1; sb = 2'b10; alu = 3'b010; end
      PH_MR:   iod = 1;
      PH_MWB:  begin m2r = 2'b01; rw = 1; end
      PH_MW:   begin iod = 1; mw = 1; end
      PH_RX:   begin sa = 1;
                 case (fn)
                   6'b100000: alu = 3'b010;
                   6'b100010: alu = 3'b110;
                   6'b100100: alu = 3'b000;
                   6'b100101: alu = 3'b001;
                   6'b101010: alu = 3'b111;
                   default:   alu = 3'b000;
                 endcase end
      PH_AWB:  begin rd = 2'b01; rw = 1; end
      PH_BR:   begin sa = 1; alu = 3'b110; ps = 2'b01;
                 pe = (op == 6'b000100) ? z : ~z; end
      PH_AX:   begin sa = 1; sb = 2'b10; alu = 3'b010; end
      PH_AWB2: rw = 1;
      PH_J:    begin ps = 2'b10; pe = 1; end
      PH_JR:   begin sa = 1; alu = 3'b010; pe = 1; end
      default: pe = 0;
    endcase
    return {pe, iod, mw, irw, rd, m2r, rw, sa, sb, alu, ps};
  endfunction

  // Phase sequence an instruction walks through; its length is the instruction latency
  task automatic plan(input logic [5:0] op, input logic [5:0] fn);
    plan_q = '{PH_F, PH_D};
    case (op)
      6'b100011: begin plan_q.push_back(PH_MA); plan_q.push_back(PH_MR); plan_q.push_back(PH_MWB); end
      6'b101011: begin plan_q.push_back(PH_MA); plan_q.push_back(PH_MW); end
      6'b000000: begin
        if (fn == 6'b001000) plan_q.push_back(PH_JR);
        else begin
          plan_q.push_back(PH_RX);
          if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010})
            plan_q.push_back(PH_AWB);
        end
      end
      6'b000100, 6'b000101: plan_q.push_back(PH_BR);
      6'b001000: begin plan_q.push_back(PH_AX); plan_q.push_back(PH_AWB2); end
      6'b000010, 6'b000011: plan_q.push_back(PH_J);
      default: ;
    endcase
  endtask

  // Called at posedge+1; drives one phase, queues its expectation, returns at next posedge+1
  task automatic drive_phase(input int ph, input logic [5:0] op, input logic [5:0] fn);
    exp_t e;
    logic [16:0] w2;
    bus.Op    = op;
    bus.Funct = fn;
    bus.Zero  = 1'($urandom_range(0, 1));
    e.w  = model(ph, op, fn, bus.Zero);
    e.ph = ph;
    q.push_back(e);
    if (ph == PH_BR) begin
      @(negedge clk);
      #1 bus.Zero = ~bus.Zero;
      w2 = model(ph, op, fn, bus.Zero);
      #1 check("branch_pc_en_follows_zero", 32'(bus.PC_En), 32'(w2[16]));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn);
    plan(op, fn);
    foreach (plan_q[i]) drive_phase(plan_q[i], op, fn);
  endtask

  // Monitor: one comparison per cycle while out of reset, plus output-legality rules
  always @(negedge clk) begin
    if (reset === 1'b1 && q.size() > 0) begin
      exp_t e;
      logic bad;
      e = q.pop_front();
      check($sformatf("ctrl_phase%0d", e.ph),
            32'({bus.PC_En, bus.I_or_D, bus.Mem_Write, bus.IR_Write, bus.Reg_Dst,
                 bus.Mem_to_Reg, bus.Reg_Write, bus.ALU_Src_A, bus.ALU_Src_B,
                 bus.ALU_Control, bus.PC_Src}), 32'(e.w));
      bad = bus.Mem_to_Reg[1] | (bus.Reg_Dst == 2'b11) | (bus.PC_Src == 2'b11) |
            (bus.Mem_Write & bus.Reg_Write) | (bus.IR_Write & (e.ph != PH_F));
      check("output_legality", 32'(bad), 32'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] fw;
    logic [5:0]  op, fn;
    reset = 1'b0;
    bus.Op = 6'b100011; bus.Funct = 6'b000000; bus.Zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    fw = model(PH_F, 6'd0, 6'd0, 1'b0);
    fw[16] = 1'b0; fw[13] = 1'b0;
    check("reset_outputs", 32'({bus.PC_En, bus.I_or_D, bus.Mem_Write, bus.IR_Write, bus.Reg_Dst,
                               bus.Mem_to_Reg, bus.Reg_Write, bus.ALU_Src_A, bus.ALU_Src_B,
                               bus.ALU_Control, bus.PC_Src}), 32'(fw));
    reset = 1'b1;

    run_instr(6'b100011, 6'b000000);
    run_instr(6'b000000, 6'b101010);
    run_instr(6'b000100, 6'b000000);
    run_instr(6'b000101, 6'b000000);
    run_instr(6'b000011, 6'b000000);
    run_instr(6'b000000, 6'b001000);
    run_instr(6'b111111, 6'b000000);
    run_instr(6'b000000, 6'b000111);
    run_instr(6'b101011, 6'b000000);
    run_instr(6'b001000, 6'b000000);
    run_instr(6'b000010, 6'b000000);

    for (int n = 0; n < 60; n++) begin
      int k;
      k = int'($urandom_range(0, 9));
      if (k < 9) op = legal_ops[k];
      else begin
        op = 6'($urandom_range(0, 63));
        while (op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101,
                          6'b001000, 6'b000010, 6'b000011})
          op = 6'($urandom_range(0, 63));
      end
      if ($urandom_range(0, 3) == 0) fn = 6'($urandom_range(0, 63));
      else fn = r_functs[$urandom_range(0, 6)];
      run_instr(op, fn);
    end

    // Abort a store in MEMWR with reset
    drive_phase(PH_F, 6'b101011, 6'd0);
    drive_phase(PH_D, 6'b101011, 6'd0);
    drive_phase(PH_MA, 6'b101011, 6'd0);
    q.push_back('{model(PH_MW, 6'b101011, 6'd0, 1'b0), PH_MW});
    @(negedge clk);
    #2 reset = 1'b0;
    #1 check("async_abort_writes", 32'({bus.PC_En, bus.IR_Write, bus.Mem_Write, bus.Reg_Write}), 32'd0);
    @(posedge clk);
    #1;
    check("reset_held_fetch", 32'({bus.PC_En, bus.I_or_D, bus.Mem_Write, bus.IR_Write, bus.Reg_Dst,
                                  bus.Mem_to_Reg, bus.Reg_Write, bus.ALU_Src_A, bus.ALU_Src_B,
                                  bus.ALU_Control, bus.PC_Src}), 32'(fw));
    reset = 1'b1;
    run_instr(6'b100011, 6'b000000);
    run_instr(6'b000000, 6'b100010);

    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have parameter: STATE_WIDTH, 4, width of the encoded state exported on State.
REQ-002 SHALL have port: clk  in  1  single clock, all state changes on rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low; one clock, reset is asynchronous and active-low.
REQ-004 SHALL have port: Op  in  6  instruction opcode (Instr[31:26]).
REQ-005 SHALL have port: Funct  in  6  R-type function field (Instr[5:0]).
REQ-006 SHALL have port: Zero  in  1  datapath ALU-result-is-zero flag.
REQ-007 SHALL have ports (out): PC_En 1, I_or_D 1, Mem_Write 1, IR_Write 1, Reg_Dst 2, Mem_to_Reg 2, Reg_Write 1, ALU_Src_A 1, ALU_Src_B 2, ALU_Control 3, PC_Src 2; datapath controls.
REQ-008 SHALL have port: State  out  STATE_WIDTH  current FSM state, for debug.

Function
REQ-009 SHALL be a multicycle FSM; Moore outputs, except PC_En in BRANCH and the link write in DECODE.
REQ-010 SHALL use ALU_Control codes AND=000, OR=001, ADD=010, SUB=110, SLT=111.
REQ-011 SHALL default every output to 0 in any state unless listed; mux selects default to 00.
REQ-012 FETCH: I_or_D=0, ALU_Src_A=0, ALU_Src_B=01, ADD, PC_Src=00, IR_Write=1, PC_En=1; next DECODE.
REQ-013 DECODE: ALU_Src_A=0, ALU_Src_B=11, ADD (branch target into ALU_Out); if Op=000011 (jal), also Reg_Dst=10, Mem_to_Reg=00, Reg_Write=1 (ALU_Out holds PC+4).
REQ-014 DECODE next: lw 100011/sw 101011->MEMADR; R 000000->RTYPE_EX, or JR when Funct=001000; beq 000100/bne 000101->BRANCH; addi 001000->ADDI_EX; j 000010/jal 000011->JUMP; any other Op->FETCH with no writes.
REQ-015 MEMADR: ALU_Src_A=1, ALU_Src_B=10, ADD; next MEMRD if lw, MEMWR if sw.
REQ-016 MEMRD: I_or_D=1; next MEMWB.  MEMWB: Reg_Dst=00, Mem_to_Reg=01, Reg_Write=1; next FETCH.
REQ-017 MEMWR: I_or_D=1, Mem_Write=1; next FETCH.
REQ-018 RTYPE_EX: ALU_Src_A=1, ALU_Src_B=00; Funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT; next ALU_WB; unknown Funct->FETCH with no writes.
REQ-019 ALU_WB: Reg_Dst=01, Mem_to_Reg=00, Reg_Write=1; next FETCH.
REQ-020 BRANCH: ALU_Src_A=1, ALU_Src_B=00, SUB, PC_Src=01; PC_En=Zero for beq, ~Zero for bne (combinational, same cycle); next FETCH.
REQ-021 ADDI_EX: ALU_Src_A=1, ALU_Src_B=10, ADD; next ADDI_WB.  ADDI_WB: Reg_Dst=00, Mem_to_Reg=00, Reg_Write=1; next FETCH.
REQ-022 JUMP: PC_Src=10, PC_En=1; next FETCH.
REQ-023 JR: ALU_Src_A=1, ALU_Src_B=00, ADD, PC_Src=00, PC_En=1 (rt=$0 gives A+0); next FETCH.
REQ-024 SHALL never assert Mem_to_Reg=10/11, Reg_Dst=11 or PC_Src=11.
REQ-025 SHALL never assert Mem_Write and Reg_Write in the same cycle, nor IR_Write outside FETCH.
REQ-026 Instruction latency SHALL be: lw 5; sw, R-type, addi 4; beq, bne, j, jal, jr 3; illegal 2 cycles.
REQ-027 Unused state encodings SHALL transition to FETCH with all write enables 0.

Reset
REQ-028 While reset=0, state SHALL be FETCH and PC_En, IR_Write, Mem_Write and Reg_Write SHALL be forced 0.
REQ-029 Reset asserted mid-instruction SHALL abort it immediately with no further writes; the first rising edge after release SHALL execute FETCH.

Verification
REQ-030 Release reset, Op=100011 held -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; Reg_Write=1, Mem_to_Reg=01 only in MEMWB.
REQ-031 Op=000000, Funct=101010 -> RTYPE_EX ALU_Control=111, then ALU_WB Reg_Dst=01, Reg_Write=1.
REQ-032 Op=000100, Zero=1 -> BRANCH PC_En=1, PC_Src=01; Op=000101, Zero=1 -> PC_En=0; toggle Zero within BRANCH -> PC_En follows the same cycle.
REQ-033 Op=000011 -> DECODE Reg_Write=1, Reg_Dst=10; JUMP PC_Src=10, PC_En=1; Op=000000, Funct=001000 -> JR PC_En=1, PC_Src=00.
REQ-034 Op=111111 -> DECODE then FETCH with no Reg_Write/Mem_Write; Op=000000, Funct=000111 -> RTYPE_EX then FETCH, no Reg_Write.
REQ-035 Drive reset=0 during MEMWR -> Mem_Write drops to 0 asynchronously; after release State=FETCH.
